// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: captures a 512-bit block and walks the datapath through the rounds,
// supplying Wt and Kt. Define SHA256_ROUND_CTRL_BSWAP_EN to byte-swap input words and digest words.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         iv_ld,
  output logic         soc,
  output logic         eoc,
  output logic [31:0]  Wt,
  output logic [31:0]  Kt,
  output logic [5:0]   rnd,
  input  logic [255:0] hash,
  output logic [255:0] digest,
  output logic         digest_valid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [5:0] RND_LAST = 6'(ROUNDS - 1);

  state_t      state_r;
  logic [31:0] w_r [16];
  logic        first_r;
  logic        last_r;
  logic [31:0] w_next_s;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] word_order(input logic [31:0] x);
`ifdef SHA256_ROUND_CTRL_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic logic [255:0] digest_order(input logic [255:0] h);
    logic [255:0] r;
    r = 256'h0;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = word_order(h[32*i +: 32]);
    end
    return r;
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;
      6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;
      6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;
      6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;
      6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;
      6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;
      6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;
      6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;
      6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;
      6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;
      6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;
      6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;
      6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;
      6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;
      6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;
      6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;
      6'd62: return 32'hbef9a3f7;  6'd63: return 32'hc67178f2;
      default: return 32'h00000000;
    endcase
  endfunction

  // Next schedule word entering the top of the sliding window.
  always_comb begin
    w_next_s = sig1(w_r[14]) + w_r[9] + sig0(w_r[1]) + w_r[0];
  end

  // Sequencer FSM; outputs are loaded one edge early so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      blk_ready    <= 1'b1;
      first_r      <= 1'b0;
      last_r       <= 1'b0;
      iv_ld        <= 1'b0;
      soc          <= 1'b0;
      eoc          <= 1'b0;
      Wt           <= 32'h0;
      Kt           <= 32'h0;
      rnd          <= 6'd0;
      digest       <= 256'h0;
      digest_valid <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_r[i] <= 32'h0;
      end
    end else begin
      soc          <= 1'b0;
      eoc          <= 1'b0;
      iv_ld        <= 1'b0;
      digest_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            for (int i = 0; i < 16; i++) begin
              w_r[i] <= word_order(blk_data[511 - 32*i -: 32]);
            end
            first_r   <= blk_first;
            last_r    <= blk_last;
            soc       <= 1'b1;
            iv_ld     <= blk_first;
            blk_ready <= 1'b0;
            state_r   <= LOAD;
          end
        end
        LOAD: begin
          state_r <= ROUND;
          rnd     <= 6'd0;
          Wt      <= w_r[0];
          Kt      <= k_rom(6'd0);
        end
        ROUND: begin
          for (int i = 0; i < 15; i++) begin
            w_r[i] <= w_r[i+1];
          end
          w_r[15] <= w_next_s;
          if (rnd == RND_LAST) begin
            state_r <= FINAL;
            eoc     <= 1'b1;
            rnd     <= 6'd0;
            Wt      <= 32'h0;
            Kt      <= 32'h0;
          end else begin
            rnd <= rnd + 6'd1;
            Wt  <= w_r[1];
            Kt  <= k_rom(rnd + 6'd1);
          end
        end
        FINAL: begin
          state_r   <= last_r ? DONE : IDLE;
          blk_ready <= !last_r;
        end
        DONE: begin
          digest       <= digest_order(hash);
          digest_valid <= 1'b1;
          state_r      <= IDLE;
          blk_ready    <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          blk_ready <= 1'b1;
          rnd       <= 6'd0;
          Wt        <= 32'h0;
          Kt        <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: a behavioural compression datapath closes the loop,
// and expected digests are queued at stimulus time and popped on digest_valid.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         iv_ld;
  logic         soc;
  logic         eoc;
  logic [31:0]  Wt;
  logic [31:0]  Kt;
  logic [5:0]   rnd;
  logic [255:0] hash;
  logic [255:0] digest;
  logic         digest_valid;

  sha256_round_ctrl #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
    .iv_ld(iv_ld), .soc(soc), .eoc(eoc), .Wt(Wt), .Kt(Kt), .rnd(rnd),
    .hash(hash), .digest(digest), .digest_valid(digest_valid)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_M   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  int n_chk = 0;
  int n_fail = 0;
  int n_soc = 0, n_eoc = 0, n_iv = 0, n_dv = 0;
  int cyc = 0, acc_cyc = 0;
  logic armed = 1'b0;
  logic [255:0] exp_q [$];

  logic [31:0] nxt_w0, mon_w0;
  logic nxt_first, nxt_last, nxt_c16, mon_first, mon_last, mon_c16;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] x);
`ifdef SHA256_ROUND_CTRL_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic logic [511:0] tb_in(input logic [511:0] b);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = bsw(b[32*i +: 32]);
    return r;
  endfunction

  function automatic logic [255:0] tb_dig(input logic [255:0] d);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = bsw(d[32*i +: 32]);
    return r;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  // Behavioural compression datapath driven by the controller's strobes.
  logic [255:0] hv = 256'h0;
  logic [255:0] wv = 256'h0;
  logic active = 1'b0;
  assign hash = hv;

  always @(posedge clk) begin
    if (soc) begin
      wv <= iv_ld ? IV : hv;
      if (iv_ld) hv <= IV;
      active <= 1'b1;
    end else if (eoc) begin
      hv <= add8(hv, wv);
      active <= 1'b0;
    end else if (active) begin
      wv <= sha_round(wv, Kt, Wt);
    end
  end

  // Cycle counter and accept tracking for the latency monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      armed <= 1'b0;
    end else if (blk_valid && blk_ready) begin
      armed     <= 1'b1;
      acc_cyc   <= cyc;
      mon_w0    <= nxt_w0;
      mon_first <= nxt_first;
      mon_last  <= nxt_last;
      mon_c16   <= nxt_c16;
    end
  end

  // Timing monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    int rel;
    rel = cyc - acc_cyc;
    if (soc) n_soc++;
    if (eoc) n_eoc++;
    if (iv_ld) n_iv++;
    if (digest_valid) begin
      n_dv++;
      check_eq("dv_expected", 256'(exp_q.size() > 0), 256'd1);
      if (exp_q.size() > 0) check_eq("digest", digest, exp_q.pop_front());
      check_eq("dv_latency", 256'(rel), 256'd68);
    end
    if (rst && armed) begin
      case (rel)
        1:  check_eq("load", {soc, iv_ld, rnd, Wt, Kt}, {1'b1, mon_first, 6'd0, 64'h0});
        2:  check_eq("round0", {soc, iv_ld, rnd, Kt, Wt}, {2'b00, 6'd0, 32'h428a2f98, mon_w0});
        18: if (mon_c16) check_eq("round16", {rnd, Wt}, {6'd16, 32'h61626380});
        32: check_eq("busy_ready", 256'(blk_ready), 256'd0);
        65: check_eq("round63", {rnd, Kt}, {6'd63, 32'hc67178f2});
        66: check_eq("final", {eoc, rnd, Wt, Kt}, {1'b1, 6'd0, 64'h0});
        67: check_eq("after_final", {eoc, blk_ready}, {1'b0, !mon_last});
        default: ;
      endcase
    end
  end

  task automatic offer(input logic [511:0] d, input logic f, input logic l,
                       input logic [255:0] exp, input logic want, input logic c16);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = tb_in(d);
    blk_first = f;
    blk_last  = l;
    nxt_w0    = d[511:480];
    nxt_first = f;
    nxt_last  = l;
    nxt_c16   = c16;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (blk_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("accept", 256'(ok), 256'd1);
    if (ok && want) exp_q.push_back(exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && blk_ready) break;
    end
    check_eq("drain", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    int eoc_snap, dv_snap;
    rst = 1'b1;
    blk_valid = 1'b0;
    blk_data = 512'h0;
    blk_first = 1'b0;
    blk_last = 1'b0;
    nxt_w0 = 32'h0; nxt_first = 1'b0; nxt_last = 1'b0; nxt_c16 = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_eq("reset_outs", {soc, eoc, iv_ld, digest_valid, blk_ready, rnd, Wt, Kt},
             {5'b00001, 6'd0, 64'h0});
    check_eq("reset_digest", digest, 256'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", {blk_ready, soc, digest_valid}, {1'b1, 2'b00});

    // Single block "abc".
    offer(BLK_ABC, 1'b1, 1'b1, tb_dig(DIG_ABC), 1'b1, 1'b1);
    @(negedge clk) blk_valid = 1'b0;
    drain();

    // Two-block message with blk_valid held and data changed while block 1 is busy.
    offer(BLK_M1, 1'b1, 1'b0, 256'h0, 1'b0, 1'b0);
    offer(BLK_M2, 1'b0, 1'b1, tb_dig(DIG_M), 1'b1, 1'b0);
    @(negedge clk) blk_valid = 1'b0;
    drain();

    // Abort in round 30.
    offer(BLK_ABC, 1'b1, 1'b1, 256'h0, 1'b0, 1'b1);
    @(negedge clk) blk_valid = 1'b0;
    repeat (31) @(negedge clk);
    check_eq("abort_rnd", 256'(rnd), 256'd30);
    eoc_snap = n_eoc;
    dv_snap = n_dv;
    rst = 1'b0;
    #1;
    check_eq("abort_outs", {soc, eoc, iv_ld, digest_valid, blk_ready, rnd, Wt, Kt},
             {5'b00001, 6'd0, 64'h0});
    @(negedge clk);
    check_eq("abort_outs_next", {soc, eoc, iv_ld, digest_valid, blk_ready, rnd, Wt, Kt},
             {5'b00001, 6'd0, 64'h0});
    check_eq("abort_digest", digest, 256'h0);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("abort_no_eoc", 256'(n_eoc - eoc_snap), 256'd0);
    check_eq("abort_no_dv", 256'(n_dv - dv_snap), 256'd0);

    // "abc" again after the abort.
    offer(BLK_ABC, 1'b1, 1'b1, tb_dig(DIG_ABC), 1'b1, 1'b1);
    @(negedge clk) blk_valid = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    check_eq("soc_count", 256'(n_soc), 256'd5);
    check_eq("eoc_count", 256'(n_eoc), 256'd4);
    check_eq("iv_count", 256'(n_iv), 256'd4);
    check_eq("dv_count", 256'(n_dv), 256'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
